// File: rtl/param_buffer_unit_if.sv
// Flit link bundle for the router input buffer: upstream link,
// allocator request/grant, downstream link and buffer status.
interface param_buffer_unit_if #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int DEST_W = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              req_in;
  logic [FLIT_W-1:0] data_in;
  logic              ack_in;
  logic              req_port;
  logic              grant_port;
  logic              req_out;
  logic [FLIT_W-1:0] data_out;
  logic              ack_out;
  logic [DEST_W-1:0] dest_out;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  logic              err;

  modport master (
    output req_in, data_in, grant_port, ack_out,
    input  ack_in, req_port, req_out, data_out,
    input  dest_out, empty, full, count, err
  );

  modport slave (
    input  req_in, data_in, grant_port, ack_out,
    output ack_in, req_port, req_out, data_out,
    output dest_out, empty, full, count, err
  );
endinterface

// File: rtl/param_buffer_unit.sv
// Router input buffer: flit FIFO with 4-phase in/out handshakes,
// packet legality tracking and SAF/wormhole output arbitration.
module param_buffer_unit #(
  parameter int FLIT_W      = 16,
  parameter int DEPTH       = 4,
  parameter int DEST_W      = 4,
  parameter int CUT_THROUGH = 0
) (
  input logic clk,
  input logic rst,
  param_buffer_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] T_HDR = 2'b01;

  typedef enum logic {IN_IDLE, IN_ACK} in_st_e;
  typedef enum logic [1:0] {
    OUT_IDLE, OUT_REQ, OUT_SEND, OUT_WAIT
  } out_st_e;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q, pkt_q;
  logic              in_open_q;
  logic              wr_vld_q;
  logic [FLIT_W-1:0] wr_data_q;
  logic              err_q;
  logic              last_q;
  logic [DEST_W-1:0] dest_q;
  in_st_e            in_q, in_d;
  out_st_e           out_q, out_d;

  logic              full, empty;
  logic              cap, legal;
  logic [1:0]        in_ty, hd_ty;
  logic [FLIT_W-1:0] hd;
  logic              pop, drop, take_dest;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign in_ty = bus.data_in[FLIT_W-1 -: 2];
  assign hd    = mem_q[rd_q];
  assign hd_ty = hd[FLIT_W-1 -: 2];
  assign cap   = (in_q == IN_IDLE) && bus.req_in && !full;
  // bit0 of the type marks a packet opener (header, head+tail)
  assign legal = in_open_q ? !in_ty[0] : in_ty[0];

  // Input handshake state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_q <= IN_IDLE;
    else      in_q <= in_d;
  end

  // Input handshake next state
  always_comb begin
    in_d = in_q;
    unique case (in_q)
      IN_IDLE: if (cap) in_d = IN_ACK;
      IN_ACK:  if (!bus.req_in) in_d = IN_IDLE;
    endcase
  end

  // Capture stage: legality, packet tracking, error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
      in_open_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_vld_q <= cap && legal;
      err_q    <= (cap && !legal) || drop;
      if (cap) wr_data_q <= bus.data_in;
      if (cap && legal) begin
        if (in_ty == T_HDR) in_open_q <= 1'b1;
        else if (in_ty[1])  in_open_q <= 1'b0;
      end
    end
  end

  // Flit storage
  always_ff @(posedge clk) begin
    if (wr_vld_q) mem_q[wr_q] <= wr_data_q;
  end

  // Pointers, occupancy, packet count, output FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      pkt_q  <= '0;
      last_q <= 1'b0;
      dest_q <= '0;
      out_q  <= OUT_IDLE;
    end else begin
      out_q <= out_d;
      if (wr_vld_q) wr_q <= wr_q + 1'b1;
      if (pop)      rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_vld_q) - CW'(pop);
      pkt_q <= pkt_q + CW'(wr_vld_q && wr_data_q[FLIT_W-1])
                     - CW'(pop && hd_ty[1]);
      if (pop)       last_q <= hd_ty[1];
      if (take_dest) dest_q <= hd[DEST_W-1:0];
    end
  end

  // Output FSM next state and FIFO pop strobes
  always_comb begin
    out_d     = out_q;
    pop       = 1'b0;
    drop      = 1'b0;
    take_dest = 1'b0;
    unique case (out_q)
      OUT_IDLE: begin
        if (!empty) begin
          if (hd_ty[0]) begin
            if ((CUT_THROUGH != 0) || (pkt_q != '0) || full) begin
              out_d     = OUT_REQ;
              take_dest = 1'b1;
            end
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      OUT_REQ:  if (bus.grant_port) out_d = OUT_SEND;
      OUT_SEND: begin
        if (bus.ack_out && !empty) begin
          pop   = 1'b1;
          out_d = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (!bus.ack_out) out_d = last_q ? OUT_IDLE : OUT_SEND;
      end
    endcase
  end

  // Moore outputs and status
  always_comb begin
    bus.ack_in   = (in_q == IN_ACK);
    bus.req_port = (out_q != OUT_IDLE);
    bus.req_out  = (out_q == OUT_SEND) && !empty;
    bus.data_out = hd;
    bus.dest_out = dest_q;
    bus.empty    = empty;
    bus.full     = full;
    bus.count    = cnt_q;
    bus.err      = err_q;
  end
endmodule

// File: tb/tb_param_buffer_unit.sv
// Directed bench for param_buffer_unit: one store-and-forward and
// one wormhole instance driven through 4-phase link tasks.
module tb_param_buffer_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic e;

  always #5 clk = ~clk;

  param_buffer_unit_if #(.FLIT_W(16), .DEPTH(4), .DEST_W(4)) sb ();
  param_buffer_unit_if #(.FLIT_W(16), .DEPTH(4), .DEST_W(4)) wb ();

  param_buffer_unit #(
    .FLIT_W(16), .DEPTH(4), .DEST_W(4), .CUT_THROUGH(0)
  ) u_saf (.clk(clk), .rst(rst), .bus(sb));

  param_buffer_unit #(
    .FLIT_W(16), .DEPTH(4), .DEST_W(4), .CUT_THROUGH(1)
  ) u_wh (.clk(clk), .rst(rst), .bus(wb));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input bit w);
    return w ? wb.ack_in : sb.ack_in;
  endfunction

  function automatic logic rout_of(input bit w);
    return w ? wb.req_out : sb.req_out;
  endfunction

  function automatic logic [15:0] dout_of(input bit w);
    return w ? wb.data_out : sb.data_out;
  endfunction

  function automatic logic err_of(input bit w);
    return w ? wb.err : sb.err;
  endfunction

  task automatic set_req(input bit w, input logic v);
    if (w) wb.req_in = v;
    else   sb.req_in = v;
  endtask

  task automatic set_ack(input bit w, input logic v);
    if (w) wb.ack_out = v;
    else   sb.ack_out = v;
  endtask

  task automatic push(input bit w, input logic [15:0] d,
                      output logic errs);
    int n;
    if (w) wb.data_in = d;
    else   sb.data_in = d;
    set_req(w, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!ack_of(w) && n < 200);
    check("ack_in_up", 32'(ack_of(w)), 32'd1);
    errs = err_of(w);
    set_req(w, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end
    while (ack_of(w) && n < 200);
    check("ack_in_dn", 32'(ack_of(w)), 32'd0);
  endtask

  task automatic recv(input bit w, input logic [15:0] exp,
                      input string tag);
    int n;
    n = 0;
    while (!rout_of(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {15'd0, rout_of(w), dout_of(w)},
          {15'd0, 1'b1, exp});
    set_ack(w, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end
    while (rout_of(w) && n < 200);
    check({tag, "_rel"}, 32'(rout_of(w)), 32'd0);
    set_ack(w, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    sb.req_in = 0; sb.data_in = '0; sb.grant_port = 0; sb.ack_out = 0;
    wb.req_in = 0; wb.data_in = '0; wb.grant_port = 0; wb.ack_out = 0;
    repeat (3) @(negedge clk);
    check("rst_saf", 32'({sb.ack_in, sb.req_port, sb.req_out,
          sb.empty, sb.full, sb.err}), 32'b000100);
    check("rst_wh", 32'({wb.ack_in, wb.req_port, wb.req_out,
          wb.empty, wb.full, wb.err}), 32'b000100);
    check("rst_cnt", 32'(sb.count), 32'd0);
    check("rst_dest", 32'(sb.dest_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // store-and-forward H,P,T
    push(0, 16'h4123, e);
    check("saf_cnt1", 32'(sb.count), 32'd1);
    check("saf_noreq1", 32'(sb.req_port), 32'd0);
    push(0, 16'h0456, e);
    check("saf_cnt2", 32'(sb.count), 32'd2);
    check("saf_noreq2", 32'(sb.req_port), 32'd0);
    push(0, 16'h8789, e);
    check("saf_noreq3", 32'(sb.req_port), 32'd0);
    @(negedge clk);
    check("saf_req", 32'(sb.req_port), 32'd1);
    check("saf_dest", 32'(sb.dest_out), 32'h3);
    sb.grant_port = 1;
    recv(0, 16'h4123, "saf_d0");
    recv(0, 16'h0456, "saf_d1");
    recv(0, 16'h8789, "saf_d2");
    @(negedge clk);
    check("saf_reqdrop", 32'(sb.req_port), 32'd0);
    check("saf_empty", 32'(sb.empty), 32'd1);
    sb.grant_port = 0;

    // protocol error then single-flit packet
    push(0, 16'h0111, e);
    check("perr_err", 32'(e), 32'd1);
    check("perr_cnt", 32'(sb.count), 32'd0);
    check("perr_clr", 32'(sb.err), 32'd0);
    push(0, 16'hC005, e);
    check("ht_noerr", 32'(e), 32'd0);
    @(negedge clk);
    check("ht_req", 32'(sb.req_port), 32'd1);
    check("ht_dest", 32'(sb.dest_out), 32'h5);
    sb.grant_port = 1;
    recv(0, 16'hC005, "ht_data");
    @(negedge clk);
    check("ht_reqdrop", 32'(sb.req_port), 32'd0);
    sb.grant_port = 0;

    // 6-flit packet through a 4-deep FIFO
    push(0, 16'h4007, e);
    push(0, 16'h0001, e);
    push(0, 16'h0002, e);
    push(0, 16'h0003, e);
    check("full_flag", 32'(sb.full), 32'd1);
    check("full_cnt", 32'(sb.count), 32'd4);
    fork
      begin
        push(0, 16'h0004, e);
        push(0, 16'h8006, e);
      end
      begin
        repeat (6) @(negedge clk);
        check("full_hold", 32'(sb.ack_in), 32'd0);
        check("full_still", 32'(sb.full), 32'd1);
        check("full_fbreq", 32'(sb.req_port), 32'd1);
        check("full_nogo", 32'(sb.req_out), 32'd0);
        check("full_dest", 32'(sb.dest_out), 32'h7);
        sb.grant_port = 1;
        recv(0, 16'h4007, "full_d0");
        recv(0, 16'h0001, "full_d1");
        recv(0, 16'h0002, "full_d2");
        recv(0, 16'h0003, "full_d3");
        recv(0, 16'h0004, "full_d4");
        recv(0, 16'h8006, "full_d5");
      end
    join
    @(negedge clk);
    check("full_end", 32'({sb.req_port, sb.empty}), 32'b01);
    sb.grant_port = 0;

    // wormhole latency and underflow
    wb.grant_port = 1;
    push(1, 16'h400A, e);
    check("wh_lat1", 32'({wb.req_port, wb.req_out}), 32'b00);
    @(negedge clk);
    check("wh_lat2", 32'({wb.req_port, wb.req_out}), 32'b10);
    check("wh_dest", 32'(wb.dest_out), 32'hA);
    @(negedge clk);
    check("wh_lat3", 32'(wb.req_out), 32'd1);
    recv(1, 16'h400A, "wh_h");
    repeat (3) @(negedge clk);
    check("wh_under", 32'({wb.req_port, wb.req_out, wb.empty}),
          32'b101);
    push(1, 16'h0BB1, e);
    recv(1, 16'h0BB1, "wh_p");
    push(1, 16'h8CC2, e);
    recv(1, 16'h8CC2, "wh_t");
    @(negedge clk);
    check("wh_reqdrop", 32'(wb.req_port), 32'd0);

    // simultaneous push and pop at count 2
    push(1, 16'h4001, e);
    push(1, 16'h0002, e);
    check("sim_pre", 32'(wb.count), 32'd2);
    check("sim_rdy", {15'd0, wb.req_out, wb.data_out},
          {15'd0, 1'b1, 16'h4001});
    wb.data_in = 16'h8003;
    wb.req_in = 1;
    @(negedge clk);
    check("sim_ack", 32'(wb.ack_in), 32'd1);
    wb.req_in = 0;
    wb.ack_out = 1;
    @(negedge clk);
    check("sim_cnt", 32'(wb.count), 32'd2);
    check("sim_pkt", 32'(u_wh.pkt_q), 32'd1);
    wb.ack_out = 0;
    recv(1, 16'h0002, "sim_p");
    recv(1, 16'h8003, "sim_t");
    @(negedge clk);
    check("sim_end", 32'({wb.req_port, wb.empty}), 32'b01);
    check("sim_pkt0", 32'(u_wh.pkt_q), 32'd0);

    // reset in the middle of a packet
    wb.grant_port = 0;
    push(1, 16'h4007, e);
    wb.data_in = 16'h0001;
    wb.req_in = 1;
    @(negedge clk);
    check("mid_ack", 32'({wb.ack_in, wb.req_port}), 32'b11);
    rst = 1'b0;
    #1;
    check("mid_rst", 32'({wb.ack_in, wb.req_port, wb.req_out,
          wb.empty, wb.full, wb.err}), 32'b000100);
    check("mid_cnt", 32'(wb.count), 32'd0);
    wb.req_in = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(1, 16'hC00E, e);
    check("post_noerr", 32'(e), 32'd0);
    wb.grant_port = 1;
    recv(1, 16'hC00E, "post_ht");
    @(negedge clk);
    check("post_drop", 32'({wb.req_port, wb.empty}), 32'b01);
    wb.grant_port = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
